// File: rtl/cache_line_xfr_ctrl_pkg.sv
// Shared types and width helpers for the cache line transfer controller.
package cache_xfr_pkg;

   // Default parameter values for the transfer controller.
   localparam int unsigned LINE_WORDS_DEF  = 512;
   localparam int unsigned LINE_ADDR_W_DEF = 23;
   localparam int unsigned TIMEOUT_DEF     = 1024;

   // Transfer controller states; IDLE must stay at encoding 0.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      EVICT_REQ = 3'd1,
      EVICT_XFR = 3'd2,
      FILL_REQ  = 3'd3,
      FILL_XFR  = 3'd4,
      DONE      = 3'd5,
      ERR       = 3'd6
   } xfr_state_e;

   // Counter width able to index n values, never narrower than one bit.
   function automatic int unsigned width_of(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cache_line_xfr_ctrl_watchdog.sv
// Progress watchdog: counts cycles without progress, flags expiry at TIMEOUT-1.
module xfr_watchdog
   import cache_xfr_pkg::*;
#(
   parameter  int unsigned TIMEOUT = TIMEOUT_DEF,
   localparam int unsigned TO_W    = width_of(TIMEOUT)
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic progress,
   output logic expire
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   logic [TO_W-1:0] cnt;

   // Idle-cycle counter; restarts whenever the controller moves forward.
   always_ff @(posedge clk) begin
      if (rst || clear || progress) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + TO_W'(1);
      end
   end

   // Progress in the expiry cycle takes priority over the timeout.
   assign expire = !clear && !progress && (cnt == TO_LAST);

endmodule

// File: rtl/cache_line_xfr_ctrl.sv
// Moves one cache line between cache RAM and main memory: optional
// write-back of the dirty victim, then fill of the missing line.
module cache_line_xfr_ctrl
   import cache_xfr_pkg::*;
#(
   parameter  int unsigned LINE_WORDS       = LINE_WORDS_DEF,
   parameter  int unsigned LINE_ADDR_W      = LINE_ADDR_W_DEF,
   parameter  bit          FILL_AFTER_EVICT = 1'b1,
   parameter  int unsigned TIMEOUT          = TIMEOUT_DEF,
   localparam int unsigned CNT_W            = width_of(LINE_WORDS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   miss_valid,
   input  logic                   miss_dirty,
   input  logic [LINE_ADDR_W-1:0] miss_line_addr,
   input  logic [LINE_ADDR_W-1:0] victim_line_addr,
   output logic                   mem_cmd_valid,
   output logic                   mem_cmd_write,
   output logic [LINE_ADDR_W-1:0] mem_cmd_addr,
   input  logic                   mem_cmd_ready,
   input  logic                   mem_wr_ack,
   input  logic                   mem_rd_valid,
   output logic [CNT_W-1:0]       line_rd_addr,
   output logic [CNT_W-1:0]       line_wr_addr,
   output logic                   line_wr_en,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);

   xfr_state_e             state;
   logic [CNT_W-1:0]       ev_cnt;
   logic [CNT_W-1:0]       fl_cnt;
   logic [LINE_ADDR_W-1:0] miss_addr_q;
   logic                   cmd_hs;
   logic                   wr_ack;
   logic                   rd_word;
   logic                   wd_expire;

   // Qualified handshake/progress strobes; stray memory signals are ignored.
   assign cmd_hs  = mem_cmd_valid && mem_cmd_ready;
   assign wr_ack  = (state == EVICT_XFR) && mem_wr_ack;
   assign rd_word = (state == FILL_XFR) && mem_rd_valid;

   // RAM has one cycle of read latency, so address one word ahead on an ack.
   assign line_rd_addr = ev_cnt + CNT_W'(wr_ack);
   assign line_wr_addr = fl_cnt;
   assign line_wr_en   = rd_word;

   // Watchdog only exists when a timeout is configured.
   generate
      if (TIMEOUT != 0) begin : g_wd
         xfr_watchdog #(
            .TIMEOUT (TIMEOUT)
         ) u_wd (
            .clk      (clk),
            .rst      (rst),
            .clear    (!(state inside {EVICT_REQ, EVICT_XFR, FILL_REQ, FILL_XFR})),
            .progress (cmd_hs || wr_ack || rd_word),
            .expire   (wd_expire)
         );
      end else begin : g_no_wd
         assign wd_expire = 1'b0;
      end
   endgenerate

   // Transfer sequencer with registered command, status and pulse outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         ev_cnt        <= '0;
         fl_cnt        <= '0;
         miss_addr_q   <= '0;
         mem_cmd_valid <= 1'b0;
         mem_cmd_write <= 1'b0;
         mem_cmd_addr  <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (miss_valid) begin
                  miss_addr_q   <= miss_line_addr;
                  busy          <= 1'b1;
                  mem_cmd_valid <= 1'b1;
                  if (miss_dirty) begin
                     state         <= EVICT_REQ;
                     mem_cmd_write <= 1'b1;
                     mem_cmd_addr  <= victim_line_addr;
                     ev_cnt        <= '0;
                  end else begin
                     state         <= FILL_REQ;
                     mem_cmd_write <= 1'b0;
                     mem_cmd_addr  <= miss_line_addr;
                     fl_cnt        <= '0;
                  end
               end
            end
            EVICT_REQ: begin
               if (cmd_hs) begin
                  mem_cmd_valid <= 1'b0;
                  state         <= EVICT_XFR;
               end else if (wd_expire) begin
                  mem_cmd_valid <= 1'b0;
                  state         <= ERR;
                  err           <= 1'b1;
               end
            end
            EVICT_XFR: begin
               if (wr_ack) begin
                  ev_cnt <= ev_cnt + CNT_W'(1);
                  if (ev_cnt == LAST_WORD) begin
                     if (FILL_AFTER_EVICT) begin
                        state         <= FILL_REQ;
                        mem_cmd_valid <= 1'b1;
                        mem_cmd_write <= 1'b0;
                        mem_cmd_addr  <= miss_addr_q;
                        fl_cnt        <= '0;
                     end else begin
                        state <= DONE;
                        done  <= 1'b1;
                     end
                  end
               end else if (wd_expire) begin
                  state <= ERR;
                  err   <= 1'b1;
               end
            end
            FILL_REQ: begin
               if (cmd_hs) begin
                  mem_cmd_valid <= 1'b0;
                  state         <= FILL_XFR;
               end else if (wd_expire) begin
                  mem_cmd_valid <= 1'b0;
                  state         <= ERR;
                  err           <= 1'b1;
               end
            end
            FILL_XFR: begin
               if (rd_word) begin
                  fl_cnt <= fl_cnt + CNT_W'(1);
                  if (fl_cnt == LAST_WORD) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end else if (wd_expire) begin
                  state <= ERR;
                  err   <= 1'b1;
               end
            end
            DONE, ERR: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_line_xfr_ctrl.sv
// Scoreboard bench for cache_line_xfr_ctrl (LINE_WORDS=8).
// Instance 0: fill after evict, TIMEOUT=16. Instance 1: write-back only, no watchdog.
module tb_cache_line_xfr_ctrl;

   localparam int unsigned LW = 8;
   localparam int unsigned CW = 3;
   localparam int unsigned AW = 23;

   localparam logic [2:0] K_CMD  = 3'd0;
   localparam logic [2:0] K_WR   = 3'd1;
   localparam logic [2:0] K_DONE = 3'd2;
   localparam logic [2:0] K_ERR  = 3'd3;

   typedef struct {
      logic [2:0]  kind;
      logic [31:0] val;
      int          cyc;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          miss_valid [2];
   logic          miss_dirty;
   logic [AW-1:0] miss_addr;
   logic [AW-1:0] victim_addr;
   logic          mem_cmd_ready;
   logic          mem_wr_ack;
   logic          mem_rd_valid;

   logic          cmd_valid [2];
   logic          cmd_write [2];
   logic [AW-1:0] cmd_addr  [2];
   logic [CW-1:0] rd_addr   [2];
   logic [CW-1:0] wr_addr   [2];
   logic          wr_en     [2];
   logic          busy      [2];
   logic          done      [2];
   logic          err       [2];

   int  n_vec  = 0;
   int  n_err  = 0;
   int  cyc    = 0;
   int  t0     = 0;
   int  sel    = 0;
   bit  mon_en = 1'b0;
   ev_t exp_q [$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   cache_line_xfr_ctrl #(
      .LINE_WORDS(LW), .LINE_ADDR_W(AW), .FILL_AFTER_EVICT(1'b1), .TIMEOUT(16)
   ) dut (
      .clk(clk), .rst(rst),
      .miss_valid(miss_valid[0]), .miss_dirty(miss_dirty),
      .miss_line_addr(miss_addr), .victim_line_addr(victim_addr),
      .mem_cmd_valid(cmd_valid[0]), .mem_cmd_write(cmd_write[0]), .mem_cmd_addr(cmd_addr[0]),
      .mem_cmd_ready(mem_cmd_ready), .mem_wr_ack(mem_wr_ack), .mem_rd_valid(mem_rd_valid),
      .line_rd_addr(rd_addr[0]), .line_wr_addr(wr_addr[0]), .line_wr_en(wr_en[0]),
      .busy(busy[0]), .done(done[0]), .err(err[0])
   );

   cache_line_xfr_ctrl #(
      .LINE_WORDS(LW), .LINE_ADDR_W(AW), .FILL_AFTER_EVICT(1'b0), .TIMEOUT(0)
   ) dut_wb (
      .clk(clk), .rst(rst),
      .miss_valid(miss_valid[1]), .miss_dirty(miss_dirty),
      .miss_line_addr(miss_addr), .victim_line_addr(victim_addr),
      .mem_cmd_valid(cmd_valid[1]), .mem_cmd_write(cmd_write[1]), .mem_cmd_addr(cmd_addr[1]),
      .mem_cmd_ready(mem_cmd_ready), .mem_wr_ack(mem_wr_ack), .mem_rd_valid(mem_rd_valid),
      .line_rd_addr(rd_addr[1]), .line_wr_addr(wr_addr[1]), .line_wr_en(wr_en[1]),
      .busy(busy[1]), .done(done[1]), .err(err[1])
   );

   task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic string kind_name(input logic [2:0] k);
      case (k)
         K_CMD:   return "cmd_evt";
         K_WR:    return "wr_evt";
         K_DONE:  return "done_evt";
         default: return "err_evt";
      endcase
   endfunction

   function automatic logic [31:0] cmdv(input logic w, input logic [AW-1:0] a);
      return 32'({w, a});
   endfunction

   task automatic expect_ev(input logic [2:0] k, input logic [31:0] v, input int c);
      ev_t e;
      e.kind = k;
      e.val  = v;
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   // Compares one observed event (kind, value, cycle relative to accept) with the queue head.
   task automatic observe(input logic [2:0] k, input logic [31:0] v);
      ev_t e;
      int  rel;
      rel = cyc - t0;
      if (exp_q.size() == 0) begin
         check_eq("unexpected_evt", 72'({k, v, 32'(rel)}), 72'({3'd7, 32'hffff_ffff, 32'hffff_ffff}));
      end else begin
         e = exp_q.pop_front();
         check_eq(kind_name(e.kind), 72'({k, v, 32'(rel)}), 72'({e.kind, e.val, 32'(e.cyc)}));
      end
   endtask

   // Event monitor for the active instance, sampled mid-low-phase.
   always @(negedge clk) begin
      #2;
      if (mon_en) begin
         if (cmd_valid[sel] && mem_cmd_ready) observe(K_CMD, cmdv(cmd_write[sel], cmd_addr[sel]));
         if (wr_en[sel]) observe(K_WR, 32'(wr_addr[sel]));
         if (done[sel])  observe(K_DONE, 32'd0);
         if (err[sel])   observe(K_ERR, 32'd0);
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check_reset(input int i);
      check_eq("rst_busy",     72'(busy[i]),      72'(0));
      check_eq("rst_cmd_vld",  72'(cmd_valid[i]), 72'(0));
      check_eq("rst_wr_en",    72'(wr_en[i]),     72'(0));
      check_eq("rst_done",     72'(done[i]),      72'(0));
      check_eq("rst_err",      72'(err[i]),       72'(0));
      check_eq("rst_rd_addr",  72'(rd_addr[i]),   72'(0));
      check_eq("rst_wr_addr",  72'(wr_addr[i]),   72'(0));
      check_eq("rst_cmd_addr", 72'(cmd_addr[i]),  72'(0));
   endtask

   task automatic end_case();
      check_eq("evq_empty", 72'(exp_q.size()), 72'(0));
      exp_q.delete();
   endtask

   // Cycle 0: present a miss to one instance.
   task automatic start_miss(input int inst, input logic dirty, input logic [AW-1:0] maddr,
                             input logic [AW-1:0] vaddr, input logic ready);
      tick();
      sel              = inst;
      t0               = cyc;
      miss_valid[inst] = 1'b1;
      miss_dirty       = dirty;
      miss_addr        = maddr;
      victim_addr      = vaddr;
      mem_cmd_ready    = ready;
      mem_wr_ack       = 1'b0;
      mem_rd_valid     = 1'b0;
   endtask

   // Clean miss with ready and rd_valid continuous.
   task automatic run_clean(input int inst, input logic [AW-1:0] maddr);
      expect_ev(K_CMD, cmdv(1'b0, maddr), 1);
      for (int k = 0; k < LW; k++) expect_ev(K_WR, 32'(k), 2 + k);
      expect_ev(K_DONE, 32'd0, LW + 2);
      start_miss(inst, 1'b0, maddr, 23'h0, 1'b1);
      for (int c = 1; c <= LW + 3; c++) begin
         tick();
         miss_valid[0] = 1'b0;
         miss_valid[1] = 1'b0;
         mem_rd_valid  = (c >= 2 && c <= LW + 1);
         #1;
         if (c == 1 || c == LW + 2 || c == LW + 3)
            check_eq("clean_busy", 72'(busy[inst]), 72'(c <= LW + 2));
         if (c == 1) check_eq("clean_cmd_vld", 72'(cmd_valid[inst]), 72'(1));
      end
      end_case();
   endtask

   initial begin
      miss_valid[0] = 1'b0;
      miss_valid[1] = 1'b0;
      miss_dirty    = 1'b0;
      miss_addr     = '0;
      victim_addr   = '0;
      mem_cmd_ready = 1'b0;
      mem_wr_ack    = 1'b0;
      mem_rd_valid  = 1'b0;
      repeat (3) tick();
      #1;
      check_reset(0);
      check_reset(1);
      rst    = 1'b0;
      mon_en = 1'b1;

      // Clean miss, minimum latency.
      run_clean(0, 23'h012345);

      // Dirty miss, evict then fill, ack every other cycle.
      begin
         int nack;
         logic exp_ack;
         nack = 0;
         expect_ev(K_CMD, cmdv(1'b1, 23'h7abcde), 1);
         expect_ev(K_CMD, cmdv(1'b0, 23'h06789a), 18);
         for (int k = 0; k < LW; k++) expect_ev(K_WR, 32'(k), 19 + k);
         expect_ev(K_DONE, 32'd0, 27);
         start_miss(0, 1'b1, 23'h06789a, 23'h7abcde, 1'b1);
         for (int c = 1; c <= 28; c++) begin
            tick();
            miss_valid[0] = 1'b0;
            exp_ack       = (c >= 3 && c <= 17 && (c % 2) == 1);
            mem_wr_ack    = exp_ack;
            mem_rd_valid  = (c >= 19 && c <= 26);
            #1;
            if (c >= 2 && c <= 17) begin
               check_eq("evict_rd_addr", 72'(rd_addr[0]), 72'((nack + int'(exp_ack)) % LW));
               if (exp_ack) nack++;
            end
            if (c == 28) check_eq("evict_busy_end", 72'(busy[0]), 72'(0));
         end
         end_case();
      end

      // Dirty miss, evict then fill, continuous acks: LINE_WORDS+1 extra cycles.
      expect_ev(K_CMD, cmdv(1'b1, 23'h000111), 1);
      expect_ev(K_CMD, cmdv(1'b0, 23'h222000), 10);
      for (int k = 0; k < LW; k++) expect_ev(K_WR, 32'(k), 11 + k);
      expect_ev(K_DONE, 32'd0, 19);
      start_miss(0, 1'b1, 23'h222000, 23'h000111, 1'b1);
      for (int c = 1; c <= 20; c++) begin
         tick();
         miss_valid[0] = 1'b0;
         mem_wr_ack    = (c >= 2 && c <= 9);
         mem_rd_valid  = (c >= 11 && c <= 18);
         #1;
         if (c == 20) check_eq("evfill_busy_end", 72'(busy[0]), 72'(0));
      end
      end_case();

      // Write-back only; stray rd_valid during eviction must not write the RAM.
      expect_ev(K_CMD, cmdv(1'b1, 23'h5a5a5a), 1);
      expect_ev(K_DONE, 32'd0, 10);
      start_miss(1, 1'b1, 23'h333333, 23'h5a5a5a, 1'b1);
      for (int c = 1; c <= 11; c++) begin
         tick();
         miss_valid[1] = 1'b0;
         mem_wr_ack    = (c >= 2 && c <= 9);
         mem_rd_valid  = (c >= 2 && c <= 9);
         #1;
         if (c >= 2 && c <= 9) check_eq("wb_no_wr_en", 72'(wr_en[1]), 72'(0));
         if (c == 11) check_eq("wb_busy_end", 72'(busy[1]), 72'(0));
      end
      end_case();

      // Timeout: fill stalls after word 3, err after 16 idle cycles.
      expect_ev(K_CMD, cmdv(1'b0, 23'h444444), 1);
      for (int k = 0; k < 4; k++) expect_ev(K_WR, 32'(k), 2 + k);
      expect_ev(K_ERR, 32'd0, 22);
      start_miss(0, 1'b0, 23'h444444, 23'h0, 1'b1);
      for (int c = 1; c <= 23; c++) begin
         tick();
         miss_valid[0] = 1'b0;
         mem_rd_valid  = (c >= 2 && c <= 5);
         #1;
         if (c == 21) check_eq("to_busy_pre", 72'(busy[0]), 72'(1));
         if (c == 23) check_eq("to_busy_end", 72'(busy[0]), 72'(0));
      end
      end_case();

      // Reset during fill at word 5, then a normal miss.
      expect_ev(K_CMD, cmdv(1'b0, 23'h555555), 1);
      for (int k = 0; k < 6; k++) expect_ev(K_WR, 32'(k), 2 + k);
      start_miss(0, 1'b0, 23'h555555, 23'h0, 1'b1);
      for (int c = 1; c <= 8; c++) begin
         tick();
         miss_valid[0] = 1'b0;
         mem_rd_valid  = (c >= 2);
         rst           = (c == 7);
         #1;
         if (c == 8) begin
            check_reset(0);
            rst          = 1'b0;
            mem_rd_valid = 1'b0;
         end
      end
      end_case();
      run_clean(0, 23'h666666);

      // Command held off for 10 cycles with no watchdog.
      expect_ev(K_CMD, cmdv(1'b0, 23'h0abcde), 11);
      for (int k = 0; k < LW; k++) expect_ev(K_WR, 32'(k), 12 + k);
      expect_ev(K_DONE, 32'd0, 20);
      start_miss(1, 1'b0, 23'h0abcde, 23'h0, 1'b0);
      for (int c = 1; c <= 21; c++) begin
         tick();
         miss_valid[1] = 1'b0;
         mem_cmd_ready = (c >= 11);
         mem_rd_valid  = (c >= 12 && c <= 19);
         #1;
         if (c <= 10) begin
            check_eq("hold_cmd_vld",  72'(cmd_valid[1]), 72'(1));
            check_eq("hold_cmd_addr", 72'(cmd_addr[1]),  72'(23'h0abcde));
            check_eq("hold_cmd_wr",   72'(cmd_write[1]), 72'(0));
            check_eq("hold_no_err",   72'(err[1]),       72'(0));
         end
         if (c == 21) check_eq("hold_busy_end", 72'(busy[1]), 72'(0));
      end
      end_case();

      repeat (2) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
